conv_window_engine: RTL and testbench

CONV_WINDOW_ENGINE -- requirements
Module: conv_window_engine

---
 rtl/cwe_pkg.sv | 22 ++
 rtl/cwe_mac_lane.sv | 34 +++
 rtl/conv_window_engine.sv | 150 +++++++++++++++
 tb/tb_conv_window_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cwe_pkg.sv
// rtl/cwe_pkg.sv - shared FSM state, parameter limits and width helper for conv_window_engine
package cwe_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } cwe_state_t;

  localparam int K_MIN    = 2;
  localparam int K_MAX    = 4;
  localparam int NF_MIN   = 1;
  localparam int NF_MAX   = 8;
  localparam int COLS_MIN = K_MIN;
  localparam int COLS_MAX = 64;

  // Room for K*K full-precision products without overflow.
  function automatic int cwe_aw(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

endpackage

// File: rtl/cwe_mac_lane.sv
// rtl/cwe_mac_lane.sv - one signed multiply-accumulate lane with optional ReLU on the latched result
module cwe_mac_lane
  import cwe_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 clr,
  input  logic                 latch,
  input  logic                 relu,
  input  logic signed [DW-1:0] px,
  input  logic signed [DW-1:0] wt,
  output logic signed [AW-1:0] result
);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] prod;

  assign prod = AW'(px) * AW'(wt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (step) acc <= (clr ? '0 : acc) + prod;
      if (latch) result <= (relu && acc[AW-1]) ? '0 : acc;
    end
  end

endmodule

// File: rtl/conv_window_engine.sv
// rtl/conv_window_engine.sv - K x K sliding window over a column stream, NF filters computed by serial MAC lanes
module conv_window_engine
  import cwe_pkg::*;
#(
  parameter int DW       = 8,
  parameter int K        = 4,
  parameter int NF       = 4,
  parameter int IMG_COLS = 16,
  localparam int AW      = cwe_aw(DW, K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K*DW-1:0]   in_col,
  input  logic              w_wr,
  input  logic [2:0]        w_f,
  input  logic [3:0]        w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NF*AW-1:0]  out_data,
  output logic [5:0]        out_col
);

  localparam int         KK       = K * K;
  localparam logic [4:0] KK_L     = 5'(KK);
  localparam logic [2:0] K_L      = 3'(K);
  localparam logic [2:0] KM1_L    = 3'(K - 1);
  localparam logic [3:0] NF_L     = 4'(NF);
  localparam logic [5:0] LAST_COL = 6'(IMG_COLS - 1);

  cwe_state_t           state;
  logic [2:0]           fill;
  logic [5:0]           col_cnt;
  logic [5:0]           win_col;
  logic [4:0]           idx;
  logic                 relu_q;
  logic                 strip_end;
  logic signed [DW-1:0] win [KK];
  logic signed [DW-1:0] wts [NF][KK];
  logic signed [DW-1:0] px;
  logic signed [DW-1:0] wsel [NF];
  logic signed [AW-1:0] lane_res [NF];
  logic                 accept, w_ok, step, latch, mac_clr;

  assign accept  = (state == ST_FILL) && in_valid;
  assign w_ok    = w_wr && (state == ST_FILL) && ({1'b0, w_f} < NF_L) && ({1'b0, w_addr} < KK_L);
  assign step    = (state == ST_MAC) && (idx < KK_L);
  assign latch   = (state == ST_MAC) && (idx == KK_L);
  assign mac_clr = (idx == 5'd0);

  always_comb begin
    px = '0;
    for (int j = 0; j < KK; j++) if (idx == 5'(j)) px = win[j];
  end

  always_comb begin
    for (int f = 0; f < NF; f++) begin
      wsel[f] = '0;
      for (int j = 0; j < KK; j++) if (idx == 5'(j)) wsel[f] = wts[f][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NF; f++)
        for (int j = 0; j < KK; j++) wts[f][j] <= '0;
    end else if (w_ok) begin
      for (int f = 0; f < NF; f++)
        for (int j = 0; j < KK; j++)
          if (w_f == 3'(f) && w_addr == 4'(j)) wts[f][j] <= w_data;
    end
  end

  // Window entry r*K+c; column 0 is oldest, new column lands in column K-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < KK; j++) win[j] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r*K+c] <= win[r*K+c+1];
        win[r*K+K-1] <= in_col[r*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      fill      <= '0;
      col_cnt   <= '0;
      win_col   <= '0;
      idx       <= '0;
      relu_q    <= 1'b0;
      strip_end <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_col   <= '0;
    end else begin
      case (state)
        ST_FILL: if (accept) begin
          col_cnt <= (col_cnt == LAST_COL) ? 6'd0 : col_cnt + 6'd1;
          if (fill != K_L) fill <= fill + 3'd1;
          if (fill >= KM1_L) begin
            state     <= ST_MAC;
            in_ready  <= 1'b0;
            idx       <= '0;
            relu_q    <= relu_en;
            win_col   <= col_cnt;
            strip_end <= (col_cnt == LAST_COL);
          end
        end
        // Steps 0..KK-1 accumulate; the extra step KK latches the lane results.
        ST_MAC: begin
          idx <= idx + 5'd1;
          if (latch) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            out_col   <= win_col;
          end
        end
        ST_OUT: if (out_ready) begin
          state     <= ST_FILL;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          if (strip_end) fill <= '0;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  for (genvar f = 0; f < NF; f++) begin : g_lane
    cwe_mac_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .step   (step),
      .clr    (mac_clr),
      .latch  (latch),
      .relu   (relu_q),
      .px     (px),
      .wt     (wsel[f]),
      .result (lane_res[f])
    );
    assign out_data[f*AW +: AW] = lane_res[f];
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// tb/tb_conv_window_engine.sv - directed and random checks of conv_window_engine against a window/weight model
module tb_conv_window_engine;

  localparam int DW = 8, K = 2, NF = 2, IMG_COLS = 4;
  localparam int KK = K * K;
  localparam int AW = 2 * DW + $clog2(KK);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [K*DW-1:0]   in_col = '0;
  logic              w_wr = 1'b0;
  logic [2:0]        w_f = '0;
  logic [3:0]        w_addr = '0;
  logic [DW-1:0]     w_data = '0;
  logic              relu_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NF*AW-1:0]  out_data;
  logic [5:0]        out_col;

  conv_window_engine #(.DW(DW), .K(K), .NF(NF), .IMG_COLS(IMG_COLS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .w_wr(w_wr), .w_f(w_f), .w_addr(w_addr), .w_data(w_data), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int wm [NF][KK];
  logic [K*DW-1:0] winq [$];
  int fill_m = 0, col_m = 0;
  longint exp_lane [NF];
  int exp_col;
  bit exp_end;
  int wf_g = 0, wa_g = 0, wd_g = 0;
  bit spec_chk = 0;
  longint spec_want = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint lane(input int f);
    logic [NF*AW-1:0] d;
    logic signed [AW-1:0] s;
    d = out_data;
    s = d[f*AW +: AW];
    return longint'(s);
  endfunction

  function automatic logic [K*DW-1:0] mk_col(input int r0, input int r1);
    logic [DW-1:0] a, b;
    a = DW'(r0);
    b = DW'(r1);
    return {b, a};
  endfunction

  function automatic void model_reset();
    fill_m = 0;
    col_m = 0;
    winq.delete();
    for (int f = 0; f < NF; f++)
      for (int j = 0; j < KK; j++) wm[f][j] = 0;
  endfunction

  function automatic void model_wr(input int f, input int a, input int d);
    if (f < NF && a < KK) wm[f][a] = d;
  endfunction

  // Convolution of the last K columns: window(r,c) = column c (oldest first), row r.
  function automatic bit model_accept(input logic [K*DW-1:0] col, input bit relu);
    bit produce;
    logic [K*DW-1:0] cv;
    logic signed [DW-1:0] p;
    longint s;
    exp_col = col_m;
    exp_end = (col_m == IMG_COLS - 1);
    col_m = exp_end ? 0 : col_m + 1;
    produce = (fill_m >= K - 1);
    if (fill_m < K) fill_m++;
    winq.push_back(col);
    if (winq.size() > K) void'(winq.pop_front());
    if (produce) begin
      for (int f = 0; f < NF; f++) begin
        s = 0;
        for (int c = 0; c < K; c++) begin
          cv = winq[c];
          for (int r = 0; r < K; r++) begin
            p = cv[r*DW +: DW];
            s += longint'(p) * longint'(wm[f][r*K+c]);
          end
        end
        if (relu && s < 0) s = 0;
        exp_lane[f] = s;
      end
    end
    return produce;
  endfunction

  task automatic wr_w(input int f, input int a, input int d);
    w_wr = 1'b1; w_f = 3'(f); w_addr = 4'(a); w_data = DW'(d);
    @(posedge clk); #1;
    w_wr = 1'b0;
    model_wr(f, a, d);
  endtask

  // wr_mode: 0 none, 1 weight write alongside the column, 2 weight write during MAC
  task automatic send_col(input logic [K*DW-1:0] col, input bit relu, input int hold, input int wr_mode);
    bit produce, seen;
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", longint'(in_ready), 1);
    in_valid = 1'b1; in_col = col; relu_en = relu;
    if (wr_mode == 1) begin w_wr = 1'b1; w_f = 3'(wf_g); w_addr = 4'(wa_g); w_data = DW'(wd_g); end
    @(posedge clk); #1;
    in_valid = 1'b0; w_wr = 1'b0; relu_en = ~relu;
    if (wr_mode == 1) model_wr(wf_g, wa_g, wd_g);
    produce = model_accept(col, relu);
    n = 0;
    if (wr_mode == 2 && produce) begin
      w_wr = 1'b1; w_f = 3'(wf_g); w_addr = 4'(wa_g); w_data = DW'(wd_g);
      @(posedge clk); #1;
      w_wr = 1'b0;
      n = 1;
    end
    seen = 1'b0;
    while (n < KK + 4 && !seen) begin
      @(posedge clk); #1; n++;
      if (out_valid) seen = 1'b1;
    end
    if (!produce) begin
      chk("no_output_while_filling", longint'(seen), 0);
      chk("in_ready_while_filling", longint'(in_ready), 1);
      return;
    end
    chk("out_valid_seen", longint'(seen), 1);
    if (!seen) return;
    chk("latency", n, KK + 1);
    for (int f = 0; f < NF; f++) chk($sformatf("lane%0d", f), lane(f), exp_lane[f]);
    chk("out_col", longint'(out_col), exp_col);
    if (spec_chk) begin
      chk("spec_lane0", lane(0), spec_want);
      spec_chk = 0;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_lane0", lane(0), exp_lane[0]);
      chk("hold_lane1", lane(1), exp_lane[1]);
      chk("hold_col", longint'(out_col), exp_col);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_handshake", longint'(out_valid), 0);
    chk("ready_after_handshake", longint'(in_ready), 1);
    if (exp_end) begin fill_m = 0; winq.delete(); end
  endtask

  task automatic reset_mid_mac(input logic [K*DW-1:0] col);
    bit seen;
    in_valid = 1'b1; in_col = col;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_mac_out_valid", longint'(out_valid), 0);
    chk("rst_mac_out_data", longint'(out_data), 0);
    chk("rst_mac_out_col", longint'(out_col), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    chk("rst_mac_in_ready", longint'(in_ready), 1);
    seen = 1'b0;
    repeat (KK + 4) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("rst_mac_no_result", longint'(seen), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_out_col", longint'(out_col), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", longint'(in_ready), 1);

    for (int f = 0; f < NF; f++) for (int j = 0; j < KK; j++) wr_w(f, j, 1);
    wr_w(NF, 0, 77);
    wr_w(0, KK, 77);
    send_col(mk_col(1, 1), 0, 0, 0);
    spec_chk = 1; spec_want = 4;
    send_col(mk_col(1, 1), 0, 0, 0);

    for (int f = 0; f < NF; f++) for (int j = 0; j < KK; j++) wr_w(f, j, -1);
    send_col(mk_col(127, 127), 0, 0, 0);
    spec_chk = 1; spec_want = -508;
    send_col(mk_col(127, 127), 0, 0, 0);
    send_col(mk_col(127, 127), 1, 0, 0);
    spec_chk = 1; spec_want = 0;
    send_col(mk_col(127, 127), 1, 0, 0);

    send_col(mk_col(3, -4), 0, 10, 0);

    for (int f = 0; f < NF; f++) for (int j = 0; j < KK; j++) wr_w(f, j, 1);
    wf_g = 0; wa_g = 0; wd_g = 5;
    send_col(mk_col(5, 6), 0, 0, 2);
    send_col(mk_col(2, 2), 0, 0, 0);
    spec_chk = 1; spec_want = 6;
    send_col(mk_col(1, 1), 0, 0, 0);

    wf_g = 1; wa_g = 3; wd_g = 10;
    send_col(mk_col(4, 4), 0, 1, 1);

    reset_mid_mac(mk_col(9, 9));
    for (int f = 0; f < NF; f++)
      for (int j = 0; j < KK; j++) wr_w(f, j, int'($urandom_range(0, 255)) - 128);
    send_col(mk_col(-128, 100), 0, 0, 0);
    send_col(mk_col(50, -7), 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        wr_w(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 255)) - 128);
      wf_g = int'($urandom_range(0, 3));
      wa_g = int'($urandom_range(0, 5));
      wd_g = int'($urandom_range(0, 255)) - 128;
      send_col(mk_col(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
